// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time program loader for the instruction memory
//
// Purpose: receives a byte stream (2 header bytes holding the word count,
// count x 3-byte big-endian words, one XOR checksum byte), assembles 18-bit
// instruction words, writes them to consecutive instruction-memory addresses
// starting at BASE_ADDR, and holds the CPU in reset until the image verifies.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   rx_data_i    incoming byte
//   rx_valid_i   rx_data_i valid
//   rx_ready_o   loader accepts a byte (transfer on rx_valid_i && rx_ready_o)
//   start_i      single-cycle reload request, honoured only in DONE or ERR
//   im_we_o      instruction-memory write strobe, one cycle per word
//   im_addr_o    instruction-memory write address
//   im_wdata_o   instruction-memory write data
//   cpu_reset_o  hold-in-reset for the CPU core
//   done_o       image loaded and verified
//   err_o        load failed (bad header or checksum)
module prog_loader #(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic              start_i,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [DATA_W-1:0] im_wdata_o,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_H, S_HDR_L, S_W0, S_W1, S_W2, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t              state_q;
  logic                rx_ready_q;
  logic                im_we_q;
  logic [ADDR_W-1:0]   im_addr_q;
  logic [DATA_W-1:0]   im_wdata_q;
  logic                cpu_reset_q;
  logic                done_q;
  logic                err_q;
  logic [7:0]          cnt_hi_q;
  logic [7:0]          csum_q;
  logic [11:0]         words_left_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [1:0]          b0_q;
  logic [7:0]          b1_q;

  logic                accept;
  logic [7:0]          csum_d;
  logic [15:0]         count_d;

  assign accept  = rx_valid_i && rx_ready_q;
  assign csum_d  = csum_q ^ rx_data_i;
  assign count_d = {cnt_hi_q, rx_data_i};

  assign rx_ready_o  = rx_ready_q;
  assign im_we_o     = im_we_q;
  assign im_addr_o   = im_addr_q;
  assign im_wdata_o  = im_wdata_q;
  assign cpu_reset_o = cpu_reset_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      rx_ready_q   <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= BASE_ADDR;
      im_wdata_q   <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_hi_q     <= '0;
      csum_q       <= '0;
      words_left_q <= '0;
      idx_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q    <= S_HDR_H;
          rx_ready_q <= 1'b1;
        end
        S_HDR_H: if (accept) begin
          cnt_hi_q <= rx_data_i;
          csum_q   <= csum_d;
          state_q  <= S_HDR_L;
        end
        S_HDR_L: if (accept) begin
          csum_q       <= csum_d;
          words_left_q <= count_d[11:0];
          // Counts above 4095 cannot fit the 12-bit address space.
          if (count_d[15:12] != 4'd0) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
            rx_ready_q <= 1'b0;
          end else if (count_d[11:0] == 12'd0) begin
            state_q <= S_CHK;
          end else begin
            state_q <= S_W0;
          end
        end
        S_W0: if (accept) begin
          b0_q    <= rx_data_i[1:0];
          csum_q  <= csum_d;
          state_q <= S_W1;
        end
        S_W1: if (accept) begin
          b1_q    <= rx_data_i;
          csum_q  <= csum_d;
          state_q <= S_W2;
        end
        S_W2: if (accept) begin
          csum_q       <= csum_d;
          im_we_q      <= 1'b1;
          im_addr_q    <= BASE_ADDR + idx_q;   // wraps modulo 2^ADDR_W
          im_wdata_q   <= DATA_W'({b0_q, b1_q, rx_data_i});
          idx_q        <= idx_q + 1'b1;
          words_left_q <= words_left_q - 12'd1;
          state_q      <= (words_left_q == 12'd1) ? S_CHK : S_W0;
        end
        S_CHK: if (accept) begin
          rx_ready_q <= 1'b0;
          if (csum_q == rx_data_i) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end else begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end
        end
        S_DONE, S_ERR: if (start_i) begin
          state_q     <= S_HDR_H;
          rx_ready_q  <= 1'b1;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
          cpu_reset_q <= 1'b1;
          csum_q      <= '0;
          idx_q       <= '0;
        end
        default: begin
          state_q    <= S_IDLE;
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader (BASE 0x000 and 0xFFF instances)
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset, rx_valid, start;
  logic [7:0] rx_data;

  logic        rdy0, we0, cr0, dn0, er0;
  logic [11:0] addr0;
  logic [17:0] wd0;
  logic        rdy1, we1, cr1, dn1, er1;
  logic [11:0] addr1;
  logic [17:0] wd1;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(12), .DATA_W(18), .BASE_ADDR(12'h000)) dut0 (
    .clk_i(clk), .reset_i(reset), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rdy0), .start_i(start), .im_we_o(we0), .im_addr_o(addr0),
    .im_wdata_o(wd0), .cpu_reset_o(cr0), .done_o(dn0), .err_o(er0)
  );

  prog_loader #(.ADDR_W(12), .DATA_W(18), .BASE_ADDR(12'hFFF)) dut1 (
    .clk_i(clk), .reset_i(reset), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rdy1), .start_i(start), .im_we_o(we1), .im_addr_o(addr1),
    .im_wdata_o(wd1), .cpu_reset_o(cr1), .done_o(dn1), .err_o(er1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes of both instances
  logic [11:0] ga0[$], ga1[$];
  logic [17:0] gd0[$], gd1[$];
  int          gc0[$], gc1[$];

  always @(negedge clk) begin
    if (we0) begin ga0.push_back(addr0); gd0.push_back(wd0); gc0.push_back(cyc); end
    if (we1) begin ga1.push_back(addr1); gd1.push_back(wd1); gc1.push_back(cyc); end
  end

  // Stimulus stream, acceptance cycles and reference-model expectations
  logic [7:0]  stream[$];
  int          acc[$];
  logic [11:0] ea0[$], ea1[$];
  logic [17:0] ed[$];
  logic        exp_done, exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Parses the stream by the format rules: header count, 3-byte words, XOR checksum
  task automatic model();
    int         cnt;
    logic [7:0] x;
    logic [7:0] b0;
    ea0.delete(); ea1.delete(); ed.delete();
    x   = 8'h00;
    cnt = {stream[0], stream[1]};
    if (cnt >= 4096) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
      return;
    end
    for (int i = 0; i < 2 + 3 * cnt; i++) x = x ^ stream[i];
    for (int k = 0; k < cnt; k++) begin
      b0 = stream[2 + 3 * k];
      ed.push_back({b0[1:0], stream[3 + 3 * k], stream[4 + 3 * k]});
      ea0.push_back(12'((0 + k) % 4096));
      ea1.push_back(12'((4095 + k) % 4096));
    end
    exp_done = (x == stream[2 + 3 * cnt]);
    exp_err  = !exp_done;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rx_ready_wait", {31'd0, rdy0}, 32'd1);
    @(negedge clk);
    acc.push_back(cyc);
  endtask

  task automatic pulse_start(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s_start_cpu_reset", name), {31'd0, cr0}, 32'd1);
    chk($sformatf("%s_start_done", name), {31'd0, dn0}, 32'd0);
    chk($sformatf("%s_start_err", name), {31'd0, er0}, 32'd0);
    chk($sformatf("%s_start_ready", name), {31'd0, rdy0}, 32'd1);
  endtask

  task automatic run_load(input string name, input int gap, input bit rnd);
    int g;
    ga0.delete(); ga1.delete(); gd0.delete(); gd1.delete(); gc0.delete(); gc1.delete();
    acc.delete();
    model();
    for (int i = 0; i < stream.size(); i++) begin
      send(stream[i]);
      if (i != stream.size() - 1) begin
        g = rnd ? int'($urandom_range(0, 3)) : gap;
        if (g > 0) begin
          rx_valid = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
    end
    rx_valid = 1'b0;
    // Status must be visible in the cycle right after the final accepting edge
    chk($sformatf("%s_done", name), {31'd0, dn0}, {31'd0, exp_done});
    chk($sformatf("%s_err", name), {31'd0, er0}, {31'd0, exp_err});
    chk($sformatf("%s_cpu_reset", name), {31'd0, cr0}, {31'd0, !exp_done});
    chk($sformatf("%s_done_w", name), {31'd0, dn1}, {31'd0, exp_done});
    chk($sformatf("%s_err_w", name), {31'd0, er1}, {31'd0, exp_err});
    repeat (3) @(negedge clk);
    chk($sformatf("%s_ready_end", name), {31'd0, rdy0}, 32'd0);
    chk($sformatf("%s_done_hold", name), {31'd0, dn0}, {31'd0, exp_done});
    chk($sformatf("%s_nwrites", name), ga0.size(), ed.size());
    chk($sformatf("%s_nwrites_w", name), ga1.size(), ed.size());
    for (int k = 0; k < ed.size() && k < ga0.size() && k < ga1.size(); k++) begin
      chk($sformatf("%s_addr%0d", name, k), {20'd0, ga0[k]}, {20'd0, ea0[k]});
      chk($sformatf("%s_addr%0d_w", name, k), {20'd0, ga1[k]}, {20'd0, ea1[k]});
      chk($sformatf("%s_data%0d", name, k), {14'd0, gd0[k]}, {14'd0, ed[k]});
      chk($sformatf("%s_data%0d_w", name, k), {14'd0, gd1[k]}, {14'd0, ed[k]});
      chk($sformatf("%s_wcyc%0d", name, k), gc0[k], acc[4 + 3 * k]);
      chk($sformatf("%s_wcyc%0d_w", name, k), gc1[k], acc[4 + 3 * k]);
    end
  endtask

  task automatic check_reset_vals(input string name);
    chk($sformatf("%s_ready", name), {31'd0, rdy0}, 32'd0);
    chk($sformatf("%s_we", name), {31'd0, we0}, 32'd0);
    chk($sformatf("%s_addr", name), {20'd0, addr0}, 32'h000);
    chk($sformatf("%s_addr_w", name), {20'd0, addr1}, 32'hFFF);
    chk($sformatf("%s_wdata", name), {14'd0, wd0}, 32'd0);
    chk($sformatf("%s_cpu_reset", name), {31'd0, cr0}, 32'd1);
    chk($sformatf("%s_done", name), {31'd0, dn0}, 32'd0);
    chk($sformatf("%s_err", name), {31'd0, er0}, 32'd0);
  endtask

  task automatic set_nominal(input logic [7:0] csum);
    stream = '{8'h00, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34};
    stream.push_back(csum);
  endtask

  initial begin
    int         cnt;
    logic [7:0] x;
    logic [7:0] b;

    reset = 1'b1; rx_valid = 1'b0; start = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    #1;
    chk("post_reset_ready", {31'd0, rdy0}, 32'd0);

    set_nominal(8'h27);
    run_load("nominal", 0, 1'b0);
    chk("nominal_w0", {14'd0, gd0.size() > 0 ? gd0[0] : 18'h0}, 32'h3FFFF);

    pulse_start("thr");
    set_nominal(8'h27);
    run_load("throttled", 3, 1'b0);

    pulse_start("bcs");
    set_nominal(8'h28);
    run_load("badcsum", 0, 1'b0);

    pulse_start("bhdr");
    stream = '{8'h10, 8'h00};
    run_load("badhdr", 0, 1'b0);

    pulse_start("empty");
    stream = '{8'h00, 8'h00, 8'h00};
    run_load("empty", 0, 1'b0);

    // Reset after b1 of word 1: only word 0 may ever be written
    pulse_start("mid");
    ga0.delete(); ga1.delete(); gd0.delete(); gd1.delete(); gc0.delete(); gc1.delete();
    set_nominal(8'h27);
    for (int i = 0; i < 7; i++) send(stream[i]);
    rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    chk("midreset_nwrites", ga0.size(), 1);
    chk("midreset_nwrites_w", ga1.size(), 1);
    reset = 1'b0;
    set_nominal(8'h27);
    run_load("reload", 0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      pulse_start($sformatf("rnd%0d", t));
      if ($urandom_range(0, 7) == 0) begin
        b = 8'($urandom_range(16, 255));
        stream = '{b, 8'($urandom_range(0, 255))};
      end else begin
        cnt = int'($urandom_range(0, 5));
        stream = '{8'h00, 8'(cnt)};
        for (int i = 0; i < 3 * cnt; i++) stream.push_back(8'($urandom_range(0, 255)));
        x = 8'h00;
        for (int i = 0; i < stream.size(); i++) x = x ^ stream[i];
        if ($urandom_range(0, 3) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
        stream.push_back(x);
      end
      run_load($sformatf("rnd%0d", t), 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
